ddr4_mem_model: RTL and testbench
=================================

Name: ddr4_mem_model

Overview:
- Simplified, clock-synchronous behavioural model of one x16 DDR4 SDRAM device, used as the memory behind the DDR4 controller in system simulation.
- Decodes DDR4 command/address pins each rising edge of ddr4_ck_t and tracks per-bank open rows.
- Stores write bursts and returns read bursts on a single-data-rate split data bus: one beat per clock, no DQS.

Parameters:
- DQ_BITS, 16, data width per beat; must be a multiple of 8.
- ROW_BITS, 4, modelled row-address bits, taken from ADDR[ROW_BITS-1:0].
- COL_BITS, 6, modelled column bits, taken from ADDR[COL_BITS-1:0]; minimum 3.
- CL, 11, read latency in clocks, RD command to first read beat.
- CWL, 9, write latency in clocks, WR command to first write beat.

Ports:
- ddr4_ck_t, in, 1, the single clock; all logic on its rising edge.
- sys_rst, in, 1, reset, synchronous, active-high.
- model_enable, in, 1, low = ignore all commands and force dq_oe low.
- cke, in, 1, low = ignore commands.
- cs_n, in, 1, chip select, active low.
- act_n, in, 1, activate, active low.
- ras_n_a16, in, 1, RAS_n / A16.
- cas_n_a15, in, 1, CAS_n / A15.
- we_n_a14, in, 1, WE_n / A14.
- addr, in, 14, A13:A0.
- addr_17, in, 1, A17; ignored.
- bg, in, 1, bank group.
- ba, in, 2, bank address.
- odt, in, 1, ignored.
- dq_in, in, DQ_BITS, write beat data.
- dm_n, in, DQ_BITS/8, per-byte write mask, active low.
- dq_out, out, DQ_BITS, read beat data.
- dq_oe, out, 1, read beat valid.
- err, out, 1, sticky protocol error (only with optional feature).

Behaviour:
- Command decode happens on an edge where model_enable=1, cke=1 and cs_n=0. Otherwise the edge is DSEL: no command, but pipelines keep running.
  - act_n=0: ACT.
  - act_n=1: command selected by {ras_n_a16, cas_n_a15, we_n_a14}: 000 MRS, 001 REF, 010 PRE, 011 reserved (treat as NOP), 100 WR, 101 RD, 110 ZQC, 111 NOP.
- Bank index is {bg, ba}, 8 banks.
- Storage is an array of 8 × 2^ROW_BITS × 2^COL_BITS words, indexed {bank, row, col}. Storage is not reset. Reading a never-written location returns an unspecified value.
- ACT: open[bank] ← 1; row[bank] ← addr[ROW_BITS-1:0].
- PRE: addr[10]=1 closes all banks; otherwise closes the addressed bank.
- MRS: mr[{bg, ba}] ← addr. Stored only; has no effect on latency.
- REF, ZQC, NOP: no state change.
- WR: token {bank, row[bank], col=addr[COL_BITS-1:0]} enters a CWL-deep write delay line.
  - On emerging, the token starts an 8-beat write burst.
  - Beat k (k = 0..7) writes dq_in to column {col[COL_BITS-1:3], (col[2:0]+k) mod 8} (wrap within the 8-word block).
  - Byte j is written only if dm_n[j]=1.
- RD: same as WR, but uses a CL-deep read delay line.
  - Beat k drives dq_out with the stored word and dq_oe=1 on cycles t+CL+k, where t is the RD edge.
  - dq_out and dq_oe are registered and present on the edge after the beat cycle begins.
- Auto-precharge: for WR/RD with addr[10]=1, the bank closes immediately after its row is captured into the token.
- addr[12] (BC4) is ignored; bursts are always 8 beats.
- A token emerging while a burst of the same kind is active is dropped, and the active burst continues. The controller must space same-kind commands at least 8 cycles apart.
- A read burst and a write burst may overlap. Write-then-read to the same address is only guaranteed once the write burst has completed.
- Outside read beats: dq_oe=0, dq_out=0.
- Reset (sys_rst=1 on an edge):
  - all banks closed; delay lines and burst counters cleared; mr cleared;
  - dq_oe=0, dq_out=0, err=0;
  - an in-flight burst is aborted, and no further beats are written or driven.
- Commands presented on the reset edge are ignored.

Optional Feature:
- Macro DDR4_MODEL_ERR_CHECK_EN. When defined, err is set sticky (cleared only by reset) on any of:
  - ACT to an open bank;
  - WR or RD to a closed bank (no token is issued in this case);
  - REF while any bank is open;
  - a token dropped because of burst overlap.
- Undefined: err is tied 0. WR/RD to a closed bank then uses the stale row[bank] value.

Decomposition:
- Package ddr4_model_pkg: cmd_e enum (MRS, REF, PRE, WR, RD, ZQC, NOP, ACT, DSEL), BURST_LEN=8, NUM_BANKS=8, token struct {bank, row, col}.
- Sub-module ddr4_cmd_decode: combinational pins → cmd_e, including the enable, cke and cs_n gating.

Test Plan:
- ACT bg0 ba1 row 3; WR col 0 at t with dq_in = 16'h1000+k on beats k=0..7 from t+9; RD col 0 at t+20 → dq_oe high t+31..t+38, dq_out 16'h1000..16'h1007.
- WR col 5 with beat data A0..A7 → RD col 0 returns beat k = data written at beat (k-5) mod 8; i.e. col 5 = A0, col 0 = A3 (wrap-within-8).
- WR 16'hFFFF, then WR 16'h1234 with dm_n=2'b01 on the same column → read returns 16'hFF34.
- RD with addr[10]=1, then RD to the same bank without ACT → with DDR4_MODEL_ERR_CHECK_EN, err=1 and no second burst; without the macro, the second burst still returns data.
- cs_n=1 or cke=0 or model_enable=0 during a WR pin pattern → no write; a later read returns the old data.
- sys_rst asserted at read beat 3 → dq_oe=0 from the next edge; subsequent RD without ACT is flagged (err=1 with the macro).

Source files
------------

// File: rtl/ddr4_mem_model_pkg.sv
// ddr4_model_pkg: shared types for the DDR4 behavioural memory model.
//   cmd_e    - decoded command of one ddr4_ck_t edge (DSEL = no command)
//   token_t  - bank/row/column captured by a WR or RD command; the row and
//              column fields are sized for the widest legal configuration
//              and are truncated to ROW_BITS/COL_BITS where they are used.
package ddr4_model_pkg;

   typedef enum logic [3:0] {
      CMD_MRS,
      CMD_REF,
      CMD_PRE,
      CMD_WR,
      CMD_RD,
      CMD_ZQC,
      CMD_NOP,
      CMD_ACT,
      CMD_DSEL
   } cmd_e;

   localparam int unsigned BURST_LEN      = 8;
   localparam int unsigned NUM_BANKS      = 8;
   localparam int unsigned BANK_BITS      = 3;
   localparam int unsigned TOK_FIELD_BITS = 14;

   typedef struct packed {
      logic [BANK_BITS-1:0]      bank;
      logic [TOK_FIELD_BITS-1:0] row;
      logic [TOK_FIELD_BITS-1:0] col;
   } token_t;

endpackage

// File: rtl/ddr4_mem_model_if.sv
// ddr4_mem_model_if: command/address/data pins between a DDR4 controller
// (master) and the behavioural memory model (slave).
//   model_enable, cke, cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14,
//   addr[13:0], addr_17, bg, ba[1:0], odt  - command/address, master -> slave
//   dq_in, dm_n                            - write beat data/mask, master -> slave
//   dq_out, dq_oe                          - read beat data/valid, slave -> master
//   err                                    - sticky protocol error, slave -> master
interface ddr4_mem_model_if #(
   parameter int unsigned DQ_BITS = 16
) ();

   logic                 model_enable;
   logic                 cke;
   logic                 cs_n;
   logic                 act_n;
   logic                 ras_n_a16;
   logic                 cas_n_a15;
   logic                 we_n_a14;
   logic [13:0]          addr;
   logic                 addr_17;
   logic                 bg;
   logic [1:0]           ba;
   logic                 odt;
   logic [DQ_BITS-1:0]   dq_in;
   logic [DQ_BITS/8-1:0] dm_n;
   logic [DQ_BITS-1:0]   dq_out;
   logic                 dq_oe;
   logic                 err;

   modport master (
      output model_enable, cke, cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14,
      output addr, addr_17, bg, ba, odt, dq_in, dm_n,
      input  dq_out, dq_oe, err
   );

   modport slave (
      input  model_enable, cke, cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14,
      input  addr, addr_17, bg, ba, odt, dq_in, dm_n,
      output dq_out, dq_oe, err
   );

endinterface

// File: rtl/ddr4_mem_model_cmd_decode.sv
// ddr4_cmd_decode: combinational DDR4 command decode.
//   model_enable, cke, cs_n - gating; any inactive gives CMD_DSEL
//   act_n                   - low selects ACT regardless of the other pins
//   ras_n_a16, cas_n_a15, we_n_a14 - command field when act_n is high
//   cmd                     - decoded command
module ddr4_cmd_decode
   import ddr4_model_pkg::*;
(
   input  logic model_enable,
   input  logic cke,
   input  logic cs_n,
   input  logic act_n,
   input  logic ras_n_a16,
   input  logic cas_n_a15,
   input  logic we_n_a14,
   output cmd_e cmd
);

   always_comb begin
      cmd = CMD_DSEL;
      if (model_enable && cke && !cs_n) begin
         if (!act_n) begin
            cmd = CMD_ACT;
         end else begin
            case ({ras_n_a16, cas_n_a15, we_n_a14})
               3'b000:  cmd = CMD_MRS;
               3'b001:  cmd = CMD_REF;
               3'b010:  cmd = CMD_PRE;
               3'b100:  cmd = CMD_WR;
               3'b101:  cmd = CMD_RD;
               3'b110:  cmd = CMD_ZQC;
               default: cmd = CMD_NOP;   // 011 is reserved and behaves as NOP
            endcase
         end
      end
   end

endmodule

// File: rtl/ddr4_mem_model.sv
// ddr4_mem_model: clock-synchronous behavioural model of one x16 DDR4 device
// with a single-data-rate split data bus (one beat per clock, no DQS).
//   ddr4_ck_t - clock, all state on the rising edge
//   sys_rst   - synchronous active-high reset
//   bus       - ddr4_mem_model_if slave: command/address pins, write beats
//               (dq_in/dm_n), registered read beats (dq_out/dq_oe), err
// Optional macro DDR4_MODEL_ERR_CHECK_EN: enables the sticky err flag and
// refuses WR/RD to closed banks; without it err is tied low and WR/RD to a
// closed bank uses the last row that bank opened.
module ddr4_mem_model
   import ddr4_model_pkg::*;
#(
   parameter int unsigned DQ_BITS  = 16,
   parameter int unsigned ROW_BITS = 4,
   parameter int unsigned COL_BITS = 6,
   parameter int unsigned CL       = 11,
   parameter int unsigned CWL      = 9
) (
   input  logic             ddr4_ck_t,
   input  logic             sys_rst,
   ddr4_mem_model_if.slave  bus
);

   localparam int unsigned DM_BITS   = DQ_BITS / 8;
   localparam int unsigned MEM_AW    = BANK_BITS + ROW_BITS + COL_BITS;
   localparam int unsigned MEM_WORDS = 1 << MEM_AW;

   cmd_e                         cmd;
   logic [BANK_BITS-1:0]         bank;
   logic [NUM_BANKS-1:0]         open_q;
   logic [ROW_BITS-1:0]          row_q [NUM_BANKS];
   logic [NUM_BANKS-1:0][13:0]   mr_q;
   logic [DQ_BITS-1:0]           mem   [MEM_WORDS];

   token_t                       tok_new;
   logic                         bank_ok;
   logic                         wr_issue;
   logic                         rd_issue;

   logic [CWL-1:0]               wr_vld;
   token_t                       wr_pipe [CWL];
   logic [CL-1:0]                rd_vld;
   token_t                       rd_pipe [CL];

   logic                         wr_active;
   logic [2:0]                   wr_cnt;
   token_t                       wr_tok;
   logic                         rd_active;
   logic [2:0]                   rd_cnt;
   token_t                       rd_tok;

   logic                         wr_beat_en;
   logic                         wr_drop;
   token_t                       wr_beat_tok;
   logic [2:0]                   wr_beat_k;
   logic [MEM_AW-1:0]            wr_addr;
   logic                         rd_beat_en;
   logic                         rd_drop;
   token_t                       rd_beat_tok;
   logic [2:0]                   rd_beat_k;
   logic [MEM_AW-1:0]            rd_addr;

   logic                         dq_oe_q;
   logic [DQ_BITS-1:0]           dq_out_q;
   logic                         unused_sig;

   // Beat k of a burst addresses the column that wraps within the aligned
   // 8-word block containing the start column.
   function automatic logic [MEM_AW-1:0] beat_addr(input token_t t, input logic [2:0] k);
      return {t.bank, t.row[ROW_BITS-1:0], t.col[COL_BITS-1:3], t.col[2:0] + k};
   endfunction

   ddr4_cmd_decode u_cmd_decode (
      .model_enable (bus.model_enable),
      .cke          (bus.cke),
      .cs_n         (bus.cs_n),
      .act_n        (bus.act_n),
      .ras_n_a16    (bus.ras_n_a16),
      .cas_n_a15    (bus.cas_n_a15),
      .we_n_a14     (bus.we_n_a14),
      .cmd          (cmd)
   );

   assign bank = {bus.bg, bus.ba};

   always_comb begin
      tok_new      = '0;
      tok_new.bank = bank;
      tok_new.row  = 14'(row_q[bank]);
      tok_new.col  = 14'(bus.addr[COL_BITS-1:0]);
   end

`ifdef DDR4_MODEL_ERR_CHECK_EN
   assign bank_ok = open_q[bank];
`else
   assign bank_ok = 1'b1;
`endif

   assign wr_issue = (cmd == CMD_WR) && bank_ok;
   assign rd_issue = (cmd == CMD_RD) && bank_ok;

   // A burst's first beat comes straight from the delay-line output; the
   // remaining seven come from the latched token while *_active is set.
   always_comb begin
      wr_beat_en  = wr_active | wr_vld[CWL-1];
      wr_drop     = wr_active & wr_vld[CWL-1];
      wr_beat_tok = wr_active ? wr_tok : wr_pipe[CWL-1];
      wr_beat_k   = wr_active ? wr_cnt : 3'd0;
      wr_addr     = beat_addr(wr_beat_tok, wr_beat_k);
      rd_beat_en  = rd_active | rd_vld[CL-1];
      rd_drop     = rd_active & rd_vld[CL-1];
      rd_beat_tok = rd_active ? rd_tok : rd_pipe[CL-1];
      rd_beat_k   = rd_active ? rd_cnt : 3'd0;
      rd_addr     = beat_addr(rd_beat_tok, rd_beat_k);
   end

   // Unreset storage: row registers, token payloads and the memory array.
   always_ff @(posedge ddr4_ck_t) begin
      wr_pipe[0] <= tok_new;
      for (int unsigned i = 1; i < CWL; i++) wr_pipe[i] <= wr_pipe[i-1];
      rd_pipe[0] <= tok_new;
      for (int unsigned i = 1; i < CL; i++) rd_pipe[i] <= rd_pipe[i-1];
      if (!wr_active) wr_tok <= wr_pipe[CWL-1];
      if (!rd_active) rd_tok <= rd_pipe[CL-1];
      if (!sys_rst && cmd == CMD_ACT) row_q[bank] <= bus.addr[ROW_BITS-1:0];
      if (!sys_rst && wr_beat_en) begin
         for (int unsigned j = 0; j < DM_BITS; j++) begin
            if (bus.dm_n[j]) mem[wr_addr][8*j +: 8] <= bus.dq_in[8*j +: 8];
         end
      end
   end

   always_ff @(posedge ddr4_ck_t) begin
      if (sys_rst) begin
         open_q    <= '0;
         mr_q      <= '0;
         wr_vld    <= '0;
         rd_vld    <= '0;
         wr_active <= 1'b0;
         wr_cnt    <= '0;
         rd_active <= 1'b0;
         rd_cnt    <= '0;
         dq_oe_q   <= 1'b0;
         dq_out_q  <= '0;
      end else begin
         wr_vld[0] <= wr_issue;
         for (int unsigned i = 1; i < CWL; i++) wr_vld[i] <= wr_vld[i-1];
         rd_vld[0] <= rd_issue;
         for (int unsigned i = 1; i < CL; i++) rd_vld[i] <= rd_vld[i-1];

         case (cmd)
            CMD_ACT: open_q[bank] <= 1'b1;
            CMD_PRE: begin
               if (bus.addr[10]) open_q <= '0;
               else              open_q[bank] <= 1'b0;
            end
            CMD_MRS: mr_q[bank] <= bus.addr;
            CMD_WR, CMD_RD: begin
               if (bus.addr[10]) open_q[bank] <= 1'b0;
            end
            default: ;
         endcase

         if (wr_beat_en) begin
            wr_active <= (wr_beat_k != 3'd7);
            wr_cnt    <= wr_beat_k + 3'd1;
         end
         if (rd_beat_en) begin
            rd_active <= (rd_beat_k != 3'd7);
            rd_cnt    <= rd_beat_k + 3'd1;
         end
         dq_oe_q  <= rd_beat_en;
         dq_out_q <= rd_beat_en ? mem[rd_addr] : '0;
      end
   end

`ifdef DDR4_MODEL_ERR_CHECK_EN
   logic err_q;
   logic err_set;

   always_comb begin
      err_set = 1'b0;
      if (cmd == CMD_ACT && open_q[bank])                       err_set = 1'b1;
      if ((cmd == CMD_WR || cmd == CMD_RD) && !open_q[bank])    err_set = 1'b1;
      if (cmd == CMD_REF && (|open_q))                          err_set = 1'b1;
      if (wr_drop || rd_drop)                                   err_set = 1'b1;
   end

   always_ff @(posedge ddr4_ck_t) begin
      if (sys_rst)      err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.dq_oe  = dq_oe_q & bus.model_enable;
   assign bus.dq_out = bus.model_enable ? dq_out_q : '0;

   // Pins and state that have no observable effect in this model.
   assign unused_sig = ^{bus.addr_17, bus.odt, mr_q, open_q, wr_drop, rd_drop,
                         wr_beat_tok, rd_beat_tok};

endmodule

// File: tb/tb_ddr4_mem_model.sv
module tb_ddr4_mem_model;

   localparam int DQ  = 16;
   localparam int RB  = 4;
   localparam int CB  = 6;
   localparam int CL  = 11;
   localparam int CWL = 9;
   localparam int NC  = 4096;
`ifdef DDR4_MODEL_ERR_CHECK_EN
   localparam bit ERRCHK = 1'b1;
`else
   localparam bit ERRCHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ddr4_mem_model_if #(.DQ_BITS(DQ)) bus ();

   ddr4_mem_model #(
      .DQ_BITS  (DQ),
      .ROW_BITS (RB),
      .COL_BITS (CB),
      .CL       (CL),
      .CWL      (CWL)
   ) dut (
      .ddr4_ck_t (clk),
      .sys_rst   (rst),
      .bus       (bus)
   );

   // Reference model: memory by flat address, bank state, scheduled beats.
   logic [15:0] ref_mem [int];
   bit          m_open [8];
   int          m_row  [8];
   bit          m_err;
   bit          rd_v [NC];
   int          rd_a [NC];
   bit          wr_v [NC];
   int          wr_a [NC];
   int          wr_busy = -1;
   int          rd_busy = -1;
   bit          plan_h  [NC];
   logic [15:0] plan_dq [NC];
   logic [1:0]  plan_dm [NC];
   int          cyc    = 0;
   int          passed = 0;
   int          total  = 0;
   logic        g_en   = 1'b1;
   logic        g_cke  = 1'b1;

   function automatic int flat_addr(int b, int r, int c, int k);
      return b * 1024 + r * 64 + (c / 8) * 8 + ((c % 8) + k) % 8;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
   endtask

   task automatic schedule(input bit is_rd, input int b, input int r, input int c, input int e);
      int start;
      start = e + (is_rd ? CL : CWL);
      if (start <= (is_rd ? rd_busy : wr_busy)) begin
         m_err = m_err | ERRCHK;
      end else begin
         if (is_rd) rd_busy = start + 7; else wr_busy = start + 7;
         for (int k = 0; k < 8; k++) begin
            if (start + k < NC) begin
               if (is_rd) begin rd_v[start+k] = 1'b1; rd_a[start+k] = flat_addr(b, r, c, k); end
               else       begin wr_v[start+k] = 1'b1; wr_a[start+k] = flat_addr(b, r, c, k); end
            end
         end
      end
   endtask

   // Applies the currently driven pins to the model for the next edge,
   // advances one clock and compares outputs #1 after the edge.
   task automatic tick();
      int          e;
      int          b;
      bit          exp_oe;
      logic [15:0] exp_d;
      logic [15:0] old;
      logic [2:0]  rcw;
      bit          any_open;
      e = cyc + 1;
      bus.dq_in = plan_h[e] ? plan_dq[e] : 16'($urandom);
      bus.dm_n  = plan_h[e] ? plan_dm[e] : 2'($urandom);
      bus.model_enable = g_en;
      bus.cke          = g_cke;
      exp_oe = 1'b0;
      exp_d  = '0;
      if (rst) begin
         for (int i = 0; i < 8; i++) m_open[i] = 1'b0;
         m_err = 1'b0;
         for (int c = e; c < NC; c++) begin rd_v[c] = 1'b0; wr_v[c] = 1'b0; end
         wr_busy = -1;
         rd_busy = -1;
      end else begin
         if (rd_v[e]) begin
            exp_oe = 1'b1;
            exp_d  = ref_mem.exists(rd_a[e]) ? ref_mem[rd_a[e]] : 16'hxxxx;
         end
         if (wr_v[e]) begin
            old = ref_mem.exists(wr_a[e]) ? ref_mem[wr_a[e]] : 16'hxxxx;
            for (int j = 0; j < 2; j++) if (bus.dm_n[j]) old[8*j +: 8] = bus.dq_in[8*j +: 8];
            ref_mem[wr_a[e]] = old;
         end
         if (bus.model_enable && bus.cke && !bus.cs_n) begin
            b   = {bus.bg, bus.ba};
            rcw = {bus.ras_n_a16, bus.cas_n_a15, bus.we_n_a14};
            any_open = 1'b0;
            for (int i = 0; i < 8; i++) any_open |= m_open[i];
            if (!bus.act_n) begin
               if (m_open[b]) m_err = m_err | ERRCHK;
               m_open[b] = 1'b1;
               m_row[b]  = int'(bus.addr[RB-1:0]);
            end else begin
               case (rcw)
                  3'b010: begin
                     if (bus.addr[10]) for (int i = 0; i < 8; i++) m_open[i] = 1'b0;
                     else m_open[b] = 1'b0;
                  end
                  3'b001: if (any_open) m_err = m_err | ERRCHK;
                  3'b100, 3'b101: begin
                     if (ERRCHK && !m_open[b]) m_err = 1'b1;
                     else schedule(rcw[0], b, m_row[b], int'(bus.addr[CB-1:0]), e);
                     if (bus.addr[10]) m_open[b] = 1'b0;
                  end
                  default: ;
               endcase
            end
         end
      end
      if (!bus.model_enable) begin exp_oe = 1'b0; exp_d = '0; end
      @(posedge clk);
      #1;
      cyc = e;
      check("dq_oe", 32'(bus.dq_oe), 32'(exp_oe));
      if (!$isunknown(exp_d)) check("dq_out", 32'(bus.dq_out), 32'(exp_d));
      check("err", 32'(bus.err), 32'(m_err));
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++) begin
         bus.cs_n  = 1'b1;
         bus.act_n = 1'($urandom);
         {bus.ras_n_a16, bus.cas_n_a15, bus.we_n_a14} = 3'($urandom);
         bus.addr  = 14'($urandom);
         {bus.bg, bus.ba} = 3'($urandom);
         tick();
      end
   endtask

   task automatic issue(input logic act_n, input logic [2:0] rcw, input int b, input logic [13:0] a,
                        input logic cs_n);
      bus.cs_n  = cs_n;
      bus.act_n = act_n;
      {bus.ras_n_a16, bus.cas_n_a15, bus.we_n_a14} = rcw;
      bus.addr  = a;
      {bus.bg, bus.ba} = 3'(b);
      tick();
      bus.cs_n  = 1'b1;
   endtask

   task automatic wr(input int b, input int col, input bit ap, input logic [15:0] d [8],
                     input logic [1:0] dm, input logic cs_n);
      for (int k = 0; k < 8; k++) begin
         plan_h [cyc+1+CWL+k] = 1'b1;
         plan_dq[cyc+1+CWL+k] = d[k];
         plan_dm[cyc+1+CWL+k] = dm;
      end
      issue(1'b1, 3'b100, b, 14'(col) | (14'(ap) << 10), cs_n);
   endtask

   task automatic rd(input int b, input int col, input bit ap);
      issue(1'b1, 3'b101, b, 14'(col) | (14'(ap) << 10), 1'b0);
   endtask

   logic [15:0] d [8];

   initial begin
      rst = 1'b1;
      bus.model_enable = 1'b1;
      bus.cke = 1'b1;
      bus.cs_n = 1'b1;
      bus.act_n = 1'b1;
      {bus.ras_n_a16, bus.cas_n_a15, bus.we_n_a14} = 3'b111;
      bus.addr = '0;
      bus.addr_17 = 1'b0;
      bus.bg = 1'b0;
      bus.ba = '0;
      bus.odt = 1'b0;
      bus.dq_in = '0;
      bus.dm_n = '1;
      nop(3);
      rst = 1'b0;
      nop(2);

      // Basic write/read: ACT bg0 ba1 row 3, beats 16'h1000+k.
      issue(1'b0, 3'b111, 1, 14'd3, 1'b0);
      nop(2);
      for (int k = 0; k < 8; k++) d[k] = 16'h1000 + 16'(k);
      wr(1, 0, 1'b0, d, 2'b11, 1'b0);
      nop(19);
      rd(1, 0, 1'b0);
      nop(CL + 10);

      // Wrap within the 8-word block: write from col 5, read from col 0.
      for (int k = 0; k < 8; k++) d[k] = 16'($urandom);
      wr(1, 5, 1'b0, d, 2'b11, 1'b0);
      nop(19);
      rd(1, 0, 1'b0);
      nop(CL + 10);

      // Byte mask: FFFF then 1234 with only byte 0 enabled.
      for (int k = 0; k < 8; k++) d[k] = 16'hFFFF;
      wr(1, 8, 1'b0, d, 2'b11, 1'b0);
      nop(19);
      for (int k = 0; k < 8; k++) d[k] = 16'h1234;
      wr(1, 8, 1'b0, d, 2'b01, 1'b0);
      nop(19);
      rd(1, 8, 1'b0);
      nop(CL + 10);

      // Randomised traffic over all banks.
      issue(1'b1, 3'b010, 0, 14'h0400, 1'b0);
      for (int b = 0; b < 8; b++) issue(1'b0, 3'b111, b, 14'($urandom_range(0, 15)), 1'b0);
      nop(2);
      for (int it = 0; it < 14; it++) begin
         for (int k = 0; k < 8; k++) d[k] = 16'($urandom);
         if (it < 5 || $urandom_range(0, 1) == 0)
            wr($urandom_range(0, 7), $urandom_range(0, 63), 1'b0, d,
               (it < 5) ? 2'b11 : 2'($urandom), 1'b0);
         else
            rd($urandom_range(0, 7), $urandom_range(0, 63), 1'b0);
         nop($urandom_range(8, 12));
      end
      nop(25);

      // Same-kind overlap: second WR emerges during the first burst.
      for (int k = 0; k < 8; k++) d[k] = 16'($urandom);
      wr(2, 0, 1'b0, d, 2'b11, 1'b0);
      nop(2);
      wr(2, 8, 1'b0, d, 2'b11, 1'b0);
      nop(25);
      rd(2, 0, 1'b0);
      nop(CL + 10);

      // Auto-precharge read, then read the closed bank; REF with banks open.
      rd(3, 0, 1'b1);
      nop(9);
      rd(3, 0, 1'b0);
      nop(CL + 10);
      issue(1'b1, 3'b001, 0, 14'd0, 1'b0);
      nop(2);

      // Gated WR pin patterns must not write.
      for (int k = 0; k < 8; k++) d[k] = 16'hDEAD;
      wr(1, 0, 1'b0, d, 2'b11, 1'b1);
      nop(20);
      g_cke = 1'b0;
      wr(1, 0, 1'b0, d, 2'b11, 1'b0);
      g_cke = 1'b1;
      nop(20);
      g_en = 1'b0;
      wr(1, 0, 1'b0, d, 2'b11, 1'b0);
      g_en = 1'b1;
      nop(20);
      rd(1, 0, 1'b0);
      nop(CL + 10);

      // Reset on read beat 3 with an ACT pattern on the reset edge.
      rd(1, 0, 1'b0);
      nop(CL + 2);
      rst = 1'b1;
      issue(1'b0, 3'b111, 1, 14'd5, 1'b0);
      rst = 1'b0;
      nop(3);
      rd(1, 0, 1'b0);
      nop(CL + 10);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
